// File: rtl/ex_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ex_sequencer
//  Description : Multi-cycle execute control FSM. Accepts one decoded op per
//                valid/ready handshake, runs ALU, move/shift (1 bit/cycle) and
//                branch ops, owns the NCZV flag register and emits a single
//                write-back or branch-redirect strobe per op.
//  Revision    : 1.0  initial release
// ============================================================================
module ex_sequencer #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              in_valid,
    output logic                   in_ready,
    input  wire logic [1:0]        op_class,
    input  wire logic [2:0]        alu_oc,
    input  wire logic              use_imm,
    input  wire logic              set_flags,
    input  wire logic [2:0]        dest_reg,
    input  wire logic [DATA_W-1:0] op_a,
    input  wire logic [DATA_W-1:0] op_b,
    input  wire logic [15:0]       imm,
    input  wire logic [15:0]       offset,
    input  wire logic [3:0]        b_cond,
    input  wire logic [DATA_W-1:0] pc,
    output logic                   wb_valid,
    output logic [2:0]             wb_reg,
    output logic [DATA_W-1:0]      wb_data,
    output logic [3:0]             flags,
    output logic                   br_taken,
    output logic [DATA_W-1:0]      br_target
);

    localparam int c_MSB = DATA_W - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_in_ready;
    logic [1:0]          r_class;
    logic [2:0]          r_oc;
    logic                r_use_imm;
    logic                r_set_flags;
    logic [2:0]          r_dest;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [15:0]         r_imm;
    logic [15:0]         r_off;
    logic [3:0]          r_cond;
    logic [DATA_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_sh;
    logic [SHAMT_W-1:0]  r_cnt;
    logic [3:0]          r_flags;       // {N,C,Z,V}
    logic                r_wb_valid;
    logic [2:0]          r_wb_reg;
    logic [DATA_W-1:0]   r_wb_data;
    logic                r_br_taken;
    logic [DATA_W-1:0]   r_br_target;

    logic [DATA_W-1:0]   w_imm_sx;
    logic [DATA_W-1:0]   w_off_sx;
    logic [DATA_W-1:0]   w_opb;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_diff;
    logic [DATA_W-1:0]   w_alu_res;
    logic                w_alu_wb;
    logic                w_alu_c;
    logic                w_alu_v;
    logic [DATA_W-1:0]   w_mv_res;
    logic                w_mv_wb;
    logic                w_shift_big;
    logic                w_shift_go;
    logic [SHAMT_W-1:0]  w_shamt;
    logic [DATA_W-1:0]   w_sh_next;
    logic                w_n, w_c, w_z, w_v;
    logic                w_cond_ok;
    logic                w_br_take;
    logic [DATA_W-1:0]   w_br_tgt;

    // Operand shaping, ALU, move/shift and branch-decision logic on latched op
    always_comb begin
        w_imm_sx    = {{(DATA_W-16){r_imm[15]}}, r_imm};
        w_off_sx    = {{(DATA_W-16){r_off[15]}}, r_off};
        w_opb       = r_use_imm ? w_imm_sx : r_b;
        w_sum       = {1'b0, r_a} + {1'b0, w_opb};
        w_diff      = {1'b0, r_a} - {1'b0, w_opb};
        w_n         = r_flags[3];
        w_c         = r_flags[2];
        w_z         = r_flags[1];
        w_v         = r_flags[0];

        // ALU: logic ops and NOT leave C/V as they were
        w_alu_res   = '0;
        w_alu_wb    = 1'b1;
        w_alu_c     = w_c;
        w_alu_v     = w_v;
        case (r_oc)
            3'd1: begin
                w_alu_res = w_sum[c_MSB:0];
                w_alu_c   = w_sum[DATA_W];
                w_alu_v   = (r_a[c_MSB] == w_opb[c_MSB]) && (w_sum[c_MSB] != r_a[c_MSB]);
            end
            3'd2: begin
                w_alu_res = w_diff[c_MSB:0];
                w_alu_c   = ~w_diff[DATA_W];   // no borrow means a >= b unsigned
                w_alu_v   = (r_a[c_MSB] != w_opb[c_MSB]) && (w_diff[c_MSB] != r_a[c_MSB]);
            end
            3'd3:    w_alu_res = r_a & w_opb;
            3'd4:    w_alu_res = r_a | w_opb;
            3'd5:    w_alu_res = r_a ^ w_opb;
            3'd6:    w_alu_res = ~r_a;
            default: w_alu_wb  = 1'b0;
        endcase

        // Move/shift: a shift count outside SHAMT_W bits forces a zero result
        w_shamt     = r_imm[SHAMT_W-1:0];
        w_shift_big = |r_imm[15:SHAMT_W];
        w_shift_go  = 1'b0;
        w_mv_res    = '0;
        w_mv_wb     = 1'b1;
        case (r_oc)
            3'd0: w_mv_res = w_imm_sx;
            3'd1: w_mv_res = {r_imm, r_a[DATA_W-17:0]};
            3'd2: w_mv_res = '0;
            3'd3: w_mv_res = '1;
            3'd4, 3'd5: begin
                w_mv_res   = w_shift_big ? '0 : r_a;
                w_shift_go = !w_shift_big && (w_shamt != '0);
            end
            default: w_mv_wb = 1'b0;
        endcase
        w_sh_next   = r_oc[0] ? (r_sh >> 1) : (r_sh << 1);

        // Branch condition evaluated against the current flag register
        case (r_cond)
            4'h0:    w_cond_ok = w_z;
            4'h1:    w_cond_ok = !w_z;
            4'h2:    w_cond_ok = w_c;
            4'h3:    w_cond_ok = !w_c;
            4'h4:    w_cond_ok = w_n;
            4'h5:    w_cond_ok = !w_n;
            4'h6:    w_cond_ok = w_v;
            4'h7:    w_cond_ok = !w_v;
            4'h8:    w_cond_ok = w_c && !w_z;
            4'h9:    w_cond_ok = !(w_c && !w_z);
            4'hA:    w_cond_ok = (w_n == w_v);
            4'hB:    w_cond_ok = (w_n != w_v);
            4'hC:    w_cond_ok = !w_z && (w_n == w_v);
            4'hD:    w_cond_ok = !(!w_z && (w_n == w_v));
            4'hE:    w_cond_ok = 1'b1;
            default: w_cond_ok = 1'b0;
        endcase
        w_br_take   = 1'b0;
        w_br_tgt    = r_pc + w_off_sx;
        case (r_oc)
            3'd0:    w_br_take = 1'b1;
            3'd1:    w_br_take = w_cond_ok;
            3'd2: begin
                w_br_take = 1'b1;
                w_br_tgt  = r_a;
            end
            default: w_br_take = 1'b0;
        endcase
    end

    // Sequencer FSM with registered handshake, strobes, results and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_class     <= '0;
            r_oc        <= '0;
            r_use_imm   <= 1'b0;
            r_set_flags <= 1'b0;
            r_dest      <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_imm       <= '0;
            r_off       <= '0;
            r_cond      <= '0;
            r_pc        <= '0;
            r_sh        <= '0;
            r_cnt       <= '0;
            r_flags     <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_reg    <= '0;
            r_wb_data   <= '0;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wb_valid <= 1'b0;
                    r_br_taken <= 1'b0;
                    if (in_valid && r_in_ready) begin
                        r_class     <= op_class;
                        r_oc        <= alu_oc;
                        r_use_imm   <= use_imm;
                        r_set_flags <= set_flags;
                        r_dest      <= dest_reg;
                        r_a         <= op_a;
                        r_b         <= op_b;
                        r_imm       <= imm;
                        r_off       <= offset;
                        r_cond      <= b_cond;
                        r_pc        <= pc;
                        r_in_ready  <= 1'b0;
                        r_state     <= S_EXEC;
                    end else begin
                        r_in_ready  <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_state <= S_DONE;
                    case (r_class)
                        2'b00: begin
                            if (w_alu_wb) begin
                                r_wb_valid <= 1'b1;
                                r_wb_reg   <= r_dest;
                                r_wb_data  <= w_alu_res;
                                if (r_set_flags) begin
                                    r_flags <= {w_alu_res[c_MSB], w_alu_c,
                                                (w_alu_res == '0), w_alu_v};
                                end
                            end
                        end
                        2'b01: begin
                            if (w_shift_go) begin
                                r_sh    <= r_a;
                                r_cnt   <= w_shamt;
                                r_state <= S_SHIFT;
                            end else if (w_mv_wb) begin
                                r_wb_valid <= 1'b1;
                                r_wb_reg   <= r_dest;
                                r_wb_data  <= w_mv_res;
                            end
                        end
                        2'b10: begin
                            if (w_br_take) begin
                                r_br_taken  <= 1'b1;
                                r_br_target <= w_br_tgt;
                            end
                        end
                        default: ;
                    endcase
                end
                S_SHIFT: begin
                    r_sh  <= w_sh_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == SHAMT_W'(1)) begin
                        r_wb_valid <= 1'b1;
                        r_wb_reg   <= r_dest;
                        r_wb_data  <= w_sh_next;
                        r_state    <= S_DONE;
                    end
                end
                default: begin
                    r_wb_valid <= 1'b0;
                    r_br_taken <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign wb_valid  = r_wb_valid;
    assign wb_reg    = r_wb_reg;
    assign wb_data   = r_wb_data;
    assign flags     = r_flags;
    assign br_taken  = r_br_taken;
    assign br_target = r_br_target;

endmodule
`default_nettype wire

// File: tb/tb_ex_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_sequencer
//  Description : Self-checking scoreboard bench for ex_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ex_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op_class;
    logic [2:0]  alu_oc;
    logic        use_imm;
    logic        set_flags;
    logic [2:0]  dest_reg;
    logic [31:0] op_a, op_b, pc;
    logic [15:0] imm, offset;
    logic [3:0]  b_cond;
    logic        wb_valid;
    logic [2:0]  wb_reg;
    logic [31:0] wb_data;
    logic [3:0]  flags;
    logic        br_taken;
    logic [31:0] br_target;

    ex_sequencer #(.DATA_W(32), .SHAMT_W(5)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_class(op_class), .alu_oc(alu_oc), .use_imm(use_imm),
        .set_flags(set_flags), .dest_reg(dest_reg), .op_a(op_a), .op_b(op_b),
        .imm(imm), .offset(offset), .b_cond(b_cond), .pc(pc),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .flags(flags),
        .br_taken(br_taken), .br_target(br_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;   // {wb, br}
        logic [2:0]  r;
        logic [31:0] d;
        int          c;      // cycle the strobe must appear in
    } exp_t;

    exp_t        q[$];
    exp_t        m_e;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_ret = 0;
    logic [3:0]  mflags = 4'h0;
    logic [31:0] last_wb = 32'h0;
    logic [2:0]  rr = 3'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, cf, z, v;
        {n, cf, z, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Strobe monitor: every strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (wb_valid || br_taken) begin
            if (q.size() == 0) begin
                chk("spurious_strobe", {62'd0, wb_valid, br_taken}, 64'd0);
            end else begin
                m_e = q.pop_front();
                chk("strobe_cycle", cyc, m_e.c);
                chk("strobe_kind", {wb_valid, br_taken}, m_e.kind);
                if (m_e.kind == 2'b10) begin
                    chk("wb_reg", wb_reg, m_e.r);
                    chk("wb_data", wb_data, m_e.d);
                end else begin
                    chk("br_target", br_target, m_e.d);
                end
            end
        end
    end

    task automatic do_op(input logic [1:0] cls, input logic [2:0] oc, input logic ui,
                         input logic sf, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] im, input logic [15:0] off,
                         input logic [3:0] cond, input logic [31:0] p, input bit b2b);
        int          n, lows, sh;
        bit          ok, wb, br, arith, fv;
        logic [31:0] bv, d;
        logic [32:0] s33;
        longint      sr;
        logic        nc, nv;
        exp_t        e;
        rr = rr + 3'd1;
        op_class = cls; alu_oc = oc; use_imm = ui; set_flags = sf; dest_reg = rr;
        op_a = a; op_b = b; imm = im; offset = off; b_cond = cond; pc = p;
        in_valid = 1'b1;
        ok = 0;
        for (int t = 0; t < 50; t++) begin
            if (in_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        n = cyc;
        if (b2b) chk("cadence", n, last_ret);
        // reference model
        wb = 0; br = 0; sh = 0; d = 32'h0; arith = 0; fv = 0;
        nc = mflags[2]; nv = mflags[0];
        bv = ui ? {{16{im[15]}}, im} : b;
        case (cls)
            2'b00: begin
                fv = 1; wb = 1;
                case (oc)
                    3'd1: begin
                        s33 = {1'b0, a} + {1'b0, bv}; d = s33[31:0]; nc = s33[32];
                        sr = longint'($signed(a)) + longint'($signed(bv));
                        nv = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
                    end
                    3'd2: begin
                        d = a - bv; nc = (a >= bv);
                        sr = longint'($signed(a)) - longint'($signed(bv));
                        nv = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
                    end
                    3'd3: d = a & bv;
                    3'd4: d = a | bv;
                    3'd5: d = a ^ bv;
                    3'd6: d = ~a;
                    default: begin wb = 0; fv = 0; end
                endcase
                if (fv && sf) mflags = {d[31], nc, d == 32'h0, nv};
            end
            2'b01: begin
                wb = 1;
                case (oc)
                    3'd0: d = {{16{im[15]}}, im};
                    3'd1: d = {im, a[15:0]};
                    3'd2: d = 32'h0;
                    3'd3: d = 32'hFFFF_FFFF;
                    3'd4, 3'd5: begin
                        if (im > 16'd31) d = 32'h0;
                        else begin
                            sh = int'(im);
                            d = (oc == 3'd4) ? (a << im) : (a >> im);
                        end
                    end
                    default: wb = 0;
                endcase
            end
            2'b10: begin
                case (oc)
                    3'd0: begin br = 1; d = p + {{16{off[15]}}, off}; end
                    3'd1: begin br = cond_ok(cond, mflags); d = p + {{16{off[15]}}, off}; end
                    3'd2: begin br = 1; d = a; end
                    default: br = 0;
                endcase
            end
            default: ;
        endcase
        if (wb || br) begin
            e.kind = {wb, br}; e.r = rr; e.d = d; e.c = n + 2 + sh;
            q.push_back(e);
        end
        lows = 0; ok = 0;
        @(negedge clk);
        for (int t = 0; t < 100; t++) begin
            if (in_ready) begin ok = 1; break; end
            lows++;
            @(negedge clk);
        end
        chk("ready_timeout", ok, 1);
        chk("busy_cycles", lows, 2 + sh);
        chk("flags", flags, mflags);
        if (!wb) chk("wb_hold", wb_data, last_wb);
        if (wb) last_wb = d;
        last_ret = cyc;
        in_valid = 1'b0;
    endtask

    task automatic alu(input logic [2:0] oc, input logic ui, input logic sf,
                       input logic [31:0] a, input logic [31:0] b, input logic [15:0] im);
        do_op(2'b00, oc, ui, sf, a, b, im, 16'h0, 4'h0, 32'h0, 1);
    endtask

    task automatic mv(input logic [2:0] oc, input logic [31:0] a, input logic [15:0] im);
        do_op(2'b01, oc, 1'b0, 1'b1, a, 32'h0, im, 16'h0, 4'h0, 32'h0, 1);
    endtask

    task automatic brn(input logic [2:0] oc, input logic [3:0] c, input logic [31:0] a,
                       input logic [15:0] off, input logic [31:0] p);
        do_op(2'b10, oc, 1'b0, 1'b0, a, 32'h0, 16'h0, off, c, p, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; op_class = '0; alu_oc = '0; use_imm = 1'b0;
        set_flags = 1'b0; dest_reg = '0; op_a = '0; op_b = '0; imm = '0; offset = '0;
        b_cond = '0; pc = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", in_ready, 0);
        chk("rst_flags", flags, 0);
        chk("rst_strobes", {wb_valid, br_taken}, 0);
        chk("rst_wb_data", wb_data, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1);
        last_ret = cyc;

        // ALU
        do_op(2'b00, 3'd1, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0, 16'h0001, 16'h0, 4'h0, 32'h0, 1);
        chk("add_ovf_flags", flags, 4'b1001);
        alu(3'd2, 1'b0, 1'b1, 32'd5, 32'd5, 16'h0);
        chk("sub_eq_flags", flags, 4'b0110);
        alu(3'd3, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 16'h0);
        alu(3'd4, 1'b0, 1'b1, 32'hF000_0000, 32'h0000_000F, 16'h0);
        alu(3'd5, 1'b1, 1'b1, 32'h0000_FFFF, 32'h0, 16'hFFFF);
        alu(3'd6, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 16'h0);
        alu(3'd0, 1'b0, 1'b1, 32'h1234_5678, 32'h1, 16'h0);
        alu(3'd7, 1'b0, 1'b1, 32'h0, 32'h0, 16'h0);
        alu(3'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1, 16'h0);
        alu(3'd2, 1'b0, 1'b1, 32'h8000_0000, 32'h1, 16'h0);

        // move / shift
        mv(3'd0, 32'h0, 16'h8000);
        mv(3'd1, 32'h0000_1234, 16'hABCD);
        mv(3'd2, 32'h5555_5555, 16'h0);
        mv(3'd3, 32'h0, 16'h0);
        mv(3'd6, 32'h0, 16'h0);
        mv(3'd4, 32'h1, 16'd31);
        mv(3'd4, 32'h0000_005A, 16'd0);
        mv(3'd4, 32'h1, 16'd40);
        mv(3'd5, 32'h8000_0000, 16'd4);
        mv(3'd5, 32'hF000_000F, 16'd1);

        // branches with Z=1, C=1
        alu(3'd2, 1'b0, 1'b1, 32'd5, 32'd5, 16'h0);
        brn(3'd1, 4'h0, 32'h0, 16'hFFF0, 32'h100);
        brn(3'd1, 4'h1, 32'h0, 16'hFFF0, 32'h100);
        brn(3'd1, 4'hF, 32'h0, 16'hFFF0, 32'h100);
        for (int c = 0; c < 16; c++) brn(3'd1, 4'(c), 32'h0, 16'h0020, 32'h1000);
        brn(3'd0, 4'h0, 32'h0, 16'h0020, 32'hFFFF_FFF0);
        brn(3'd2, 4'h0, 32'hDEAD_BEEF, 16'h0, 32'h0);
        brn(3'd3, 4'hE, 32'h0, 16'h0010, 32'h0);
        do_op(2'b11, 3'd1, 1'b0, 1'b1, 32'h1, 32'h1, 16'h0, 16'h0, 4'h0, 32'h0, 1);

        // branches with N=1 (a<b), then with V=1
        alu(3'd2, 1'b0, 1'b1, 32'd3, 32'd5, 16'h0);
        for (int c = 0; c < 16; c++) brn(3'd1, 4'(c), 32'h0, 16'h0040, 32'h2000);
        alu(3'd2, 1'b0, 1'b1, 32'h8000_0000, 32'h1, 16'h0);
        for (int c = 0; c < 16; c++) brn(3'd1, 4'(c), 32'h0, 16'hFF00, 32'h3000);

        // reset in the middle of a long shift
        op_class = 2'b01; alu_oc = 3'd4; op_a = 32'h1; imm = 16'd20; dest_reg = 3'd5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_flags", flags, 0);
        chk("midrst_ready", in_ready, 0);
        chk("midrst_strobes", {wb_valid, br_taken}, 0);
        @(negedge clk);
        rst = 1'b0;
        mflags = 4'h0;
        last_wb = 32'h0;
        @(negedge clk);
        chk("midrst_ready_after", in_ready, 1);
        repeat (25) @(negedge clk);
        chk("midrst_idle_ready", in_ready, 1);
        chk("midrst_wb_data", wb_data, 0);
        do_op(2'b00, 3'd1, 1'b0, 1'b1, 32'd2, 32'd3, 16'h0, 16'h0, 4'h0, 32'h0, 0);
        mv(3'd4, 32'h3, 16'd2);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
